// File: rtl/can_bit_stuff_unit.sv
// CAN bit stuffer/destuffer with configurable run length, stuff-region enable,
// upstream hold handshake, stuff-error detection and a saturating per-frame stuff counter.
module can_bit_stuff_unit #(
   parameter int RUN_LEN = 5,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_point,
   input  logic             enable,
   input  logic             mode,
   input  logic             tx_bit_in,
   output logic             tx_ready,
   output logic             tx_bit_out,
   input  logic             rx_bit_in,
   output logic             rx_bit_out,
   output logic             rx_valid,
   output logic             stuff_err,
   output logic [CNT_W-1:0] stuff_cnt
);

   localparam int               RUN_W   = $clog2(RUN_LEN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   logic             r_prev_bit;
   logic [RUN_W-1:0] r_run_cnt;
   logic             r_enable_d;
   logic             r_mode_d;
   logic             r_rx_bit_out;
   logic             r_rx_valid;
   logic             r_stuff_err;
   logic [CNT_W-1:0] r_stuff_cnt;

   logic             w_clear;
   logic             w_stuff_due;
   logic             w_tx_stuff;
   logic             w_bit;
   logic [RUN_W-1:0] w_run_next;
   logic             w_en_rise;
   logic             w_cnt_inc;

   // A cleared run can never be due, so stale state is masked in the clearing cycle too
   assign w_clear     = !enable || (mode != r_mode_d);
   assign w_stuff_due = !w_clear && (r_run_cnt == RUN_MAX);
   assign w_tx_stuff  = !mode && w_stuff_due;
   assign w_bit       = mode ? rx_bit_in : tx_bit_in;
   assign w_run_next  = (w_bit == r_prev_bit) ? (r_run_cnt + RUN_ONE) : RUN_ONE;
   assign w_en_rise   = enable && !r_enable_d;
   assign w_cnt_inc   = sample_point && w_stuff_due && (!mode || (rx_bit_in != r_prev_bit))
                        && !w_en_rise && (r_stuff_cnt != CNT_SAT);

   assign tx_ready   = !w_tx_stuff;
   assign tx_bit_out = w_tx_stuff ? ~r_prev_bit : tx_bit_in;
   assign rx_bit_out = r_rx_bit_out;
   assign rx_valid   = r_rx_valid;
   assign stuff_err  = r_stuff_err;
   assign stuff_cnt  = r_stuff_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_bit   <= 1'b1;
         r_run_cnt    <= '0;
         r_enable_d   <= 1'b0;
         r_mode_d     <= 1'b0;
         r_rx_bit_out <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_stuff_err  <= 1'b0;
         r_stuff_cnt  <= '0;
      end else begin
         r_enable_d  <= enable;
         r_mode_d    <= mode;
         r_rx_valid  <= 1'b0;
         r_stuff_err <= 1'b0;

         if (w_clear) begin
            r_prev_bit <= 1'b1;
            r_run_cnt  <= '0;
         end else if (sample_point) begin
            if (w_stuff_due) begin
               // The stuff bit (sent or received) starts the next run
               r_run_cnt  <= RUN_ONE;
               r_prev_bit <= mode ? rx_bit_in : ~r_prev_bit;
            end else begin
               r_run_cnt  <= w_run_next;
               r_prev_bit <= w_bit;
            end
         end

         if (sample_point && mode) begin
            if (w_stuff_due) begin
               r_stuff_err <= (rx_bit_in == r_prev_bit);
            end else begin
               r_rx_valid   <= 1'b1;
               r_rx_bit_out <= rx_bit_in;
            end
         end

         if (w_en_rise) begin
            r_stuff_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_stuff_cnt <= r_stuff_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_can_bit_stuff_unit.sv
// Directed-vector bench for can_bit_stuff_unit; stimulus pushes expectations into
// queues and a single negedge monitor pops and compares them.
module tb_can_bit_stuff_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sp, en, md, txi, rxi;
   logic       tx_rdy, tx_out, rx_out, rx_v, s_err;
   logic [7:0] cnt;
   logic       sp3, en3, md3, txi3, rxi3;
   logic       tx_rdy3, tx_out3, rx_out3, rx_v3, s_err3;
   logic [7:0] cnt3;
   logic       done = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct packed { logic b; logic rdy; } tx_exp_t;
   typedef struct packed { logic err; logic b; } rx_exp_t;
   typedef struct packed { logic rdy; logic out; logic [7:0] cnt; } st_exp_t;

   tx_exp_t    tx_q[$];
   rx_exp_t    rx_q[$];
   rx_exp_t    rx3_q[$];
   st_exp_t    st_q[$];
   logic [7:0] st3_q[$];

   tx_exp_t    te;
   rx_exp_t    re;
   st_exp_t    se;
   logic [7:0] ce;

   always #5 clk = ~clk;

   can_bit_stuff_unit #(.RUN_LEN(5), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .sample_point(sp), .enable(en), .mode(md),
      .tx_bit_in(txi), .tx_ready(tx_rdy), .tx_bit_out(tx_out),
      .rx_bit_in(rxi), .rx_bit_out(rx_out), .rx_valid(rx_v),
      .stuff_err(s_err), .stuff_cnt(cnt)
   );

   can_bit_stuff_unit #(.RUN_LEN(3), .CNT_W(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .sample_point(sp3), .enable(en3), .mode(md3),
      .tx_bit_in(txi3), .tx_ready(tx_rdy3), .tx_bit_out(tx_out3),
      .rx_bit_in(rxi3), .rx_bit_out(rx_out3), .rx_valid(rx_v3),
      .stuff_err(s_err3), .stuff_cnt(cnt3)
   );

   // Monitor: all comparisons and counters live in this one process
   always @(negedge clk) begin
      if (rst_n && sp && !md) begin
         checks++;
         if (tx_q.size() == 0) begin
            errors++;
            $display("FAIL tx_tick: unexpected tick, got out=%b rdy=%b", tx_out, tx_rdy);
         end else begin
            te = tx_q.pop_front();
            if (tx_out !== te.b || tx_rdy !== te.rdy) begin
               errors++;
               $display("FAIL tx_tick: got out=%b rdy=%b, expected out=%b rdy=%b",
                        tx_out, tx_rdy, te.b, te.rdy);
            end else
               $display("tx tick out=%b rdy=%b ok", tx_out, tx_rdy);
         end
      end
      if (rx_v || s_err) begin
         checks++;
         if (rx_q.size() == 0) begin
            errors++;
            $display("FAIL rx_out: unexpected pulse valid=%b err=%b bit=%b", rx_v, s_err, rx_out);
         end else begin
            re = rx_q.pop_front();
            if (rx_v === s_err || s_err !== re.err || (!re.err && rx_out !== re.b)) begin
               errors++;
               $display("FAIL rx_out: got valid=%b err=%b bit=%b, expected err=%b bit=%b",
                        rx_v, s_err, rx_out, re.err, re.b);
            end else
               $display("rx pulse valid=%b err=%b bit=%b ok", rx_v, s_err, rx_out);
         end
      end
      if (rx_v3 || s_err3) begin
         checks++;
         if (rx3_q.size() == 0) begin
            errors++;
            $display("FAIL rx3_out: unexpected pulse valid=%b err=%b bit=%b", rx_v3, s_err3, rx_out3);
         end else begin
            re = rx3_q.pop_front();
            if (rx_v3 === s_err3 || s_err3 !== re.err || (!re.err && rx_out3 !== re.b)) begin
               errors++;
               $display("FAIL rx3_out: got valid=%b err=%b bit=%b, expected err=%b bit=%b",
                        rx_v3, s_err3, rx_out3, re.err, re.b);
            end else
               $display("rx3 pulse valid=%b err=%b bit=%b ok", rx_v3, s_err3, rx_out3);
         end
      end
      if (st_q.size() != 0) begin
         se = st_q.pop_front();
         checks++;
         if (tx_rdy !== se.rdy || tx_out !== se.out || cnt !== se.cnt) begin
            errors++;
            $display("FAIL state: got rdy=%b out=%b cnt=%0d, expected rdy=%b out=%b cnt=%0d",
                     tx_rdy, tx_out, cnt, se.rdy, se.out, se.cnt);
         end else
            $display("state rdy=%b out=%b cnt=%0d ok", tx_rdy, tx_out, cnt);
      end
      if (st3_q.size() != 0) begin
         ce = st3_q.pop_front();
         checks++;
         if (cnt3 !== ce) begin
            errors++;
            $display("FAIL cnt3: got %0d, expected %0d", cnt3, ce);
         end else
            $display("cnt3 %0d ok", cnt3);
      end
      if (done) begin
         checks++;
         if (tx_q.size() + rx_q.size() + rx3_q.size() != 0) begin
            errors++;
            $display("FAIL drain: leftover tx=%0d rx=%0d rx3=%0d, expected 0",
                     tx_q.size(), rx_q.size(), rx3_q.size());
         end
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tx_tick(input logic b, input logic exp_out, input logic exp_rdy);
      sp  = 1'b1;
      txi = b;
      tx_q.push_back('{b: exp_out, rdy: exp_rdy});
      cyc();
      sp = 1'b0;
   endtask

   task automatic rx_tick(input logic b);
      sp  = 1'b1;
      rxi = b;
      cyc();
      sp = 1'b0;
   endtask

   task automatic rx3_tick(input logic b);
      sp3  = 1'b1;
      rxi3 = b;
      cyc();
      sp3 = 1'b0;
   endtask

   task automatic exp_rx(input logic err, input logic b);
      rx_q.push_back('{err: err, b: b});
   endtask

   task automatic exp_st(input logic rdy, input logic out, input logic [7:0] c);
      st_q.push_back('{rdy: rdy, out: out, cnt: c});
      cyc();
   endtask

   initial begin
      rst_n = 1'b0;
      sp = 0; en = 0; md = 0; txi = 0; rxi = 0;
      sp3 = 0; en3 = 0; md3 = 1; txi3 = 0; rxi3 = 0;
      cyc();
      // Reset values
      exp_st(1'b1, 1'b0, 8'd0);
      txi = 1'b1;
      exp_st(1'b1, 1'b1, 8'd0);
      rst_n = 1'b1;
      cyc();

      // TX: six zeros -> stuffed 1 on 6th tick
      en = 1'b1; cyc();
      repeat (5) tx_tick(1'b0, 1'b0, 1'b1);
      tx_tick(1'b0, 1'b1, 1'b0);
      tx_tick(1'b0, 1'b0, 1'b1);
      exp_st(1'b1, 1'b0, 8'd1);
      en = 1'b0;
      exp_st(1'b1, 1'b0, 8'd1);

      // TX: 0x5 then 1x5
      en = 1'b1; cyc();
      repeat (5) tx_tick(1'b0, 1'b0, 1'b1);
      tx_tick(1'b1, 1'b1, 1'b0);
      repeat (4) tx_tick(1'b1, 1'b1, 1'b1);
      tx_tick(1'b1, 1'b0, 1'b0);
      tx_tick(1'b1, 1'b1, 1'b1);
      exp_st(1'b1, 1'b1, 8'd2);

      // TX: 4 zeros, enable dropped one cycle, 2 zeros -> no stuff, count cleared
      repeat (4) tx_tick(1'b0, 1'b0, 1'b1);
      exp_st(1'b1, 1'b0, 8'd2);
      en = 1'b0;
      exp_st(1'b1, 1'b0, 8'd2);
      en = 1'b1; cyc();
      repeat (2) tx_tick(1'b0, 1'b0, 1'b1);
      exp_st(1'b1, 1'b0, 8'd0);

      // TX: reset while a stuff bit is pending
      en = 1'b0; cyc();
      en = 1'b1; cyc();
      repeat (5) tx_tick(1'b0, 1'b0, 1'b1);
      tx_tick(1'b0, 1'b1, 1'b0);
      repeat (5) tx_tick(1'b0, 1'b0, 1'b1);
      exp_st(1'b0, 1'b1, 8'd1);
      rst_n = 1'b0;
      exp_st(1'b1, 1'b0, 8'd0);
      txi = 1'b1;
      exp_st(1'b1, 1'b1, 8'd0);
      rst_n = 1'b1;
      cyc();

      // RX: 1,1,1,1,1,0,1 -> six data 1s, stuffed 0 dropped
      en = 1'b0; md = 1'b1; cyc();
      en = 1'b1; cyc();
      repeat (6) exp_rx(1'b0, 1'b1);
      repeat (5) rx_tick(1'b1);
      rx_tick(1'b0);
      rx_tick(1'b1);
      cyc();
      exp_st(1'b1, 1'b1, 8'd1);

      // RX: six zeros -> five data bits then a stuff error
      en = 1'b0; cyc();
      en = 1'b1; cyc();
      repeat (5) exp_rx(1'b0, 1'b0);
      exp_rx(1'b1, 1'b0);
      repeat (6) rx_tick(1'b0);
      cyc();
      exp_st(1'b1, 1'b1, 8'd0);

      // RX pass-through: enable low, every tick is data, no errors
      en = 1'b0; cyc();
      repeat (7) exp_rx(1'b0, 1'b0);
      repeat (7) rx_tick(1'b0);
      cyc();
      exp_st(1'b1, 1'b1, 8'd0);

      // RUN_LEN=3 RX: 0,0,0,1,0 -> four data 0s, one stuff bit removed
      en3 = 1'b1; cyc();
      repeat (4) rx3_q.push_back('{err: 1'b0, b: 1'b0});
      rx3_tick(1'b0);
      rx3_tick(1'b0);
      rx3_tick(1'b0);
      rx3_tick(1'b1);
      rx3_tick(1'b0);
      cyc();
      st3_q.push_back(8'd1);
      cyc();

      cyc();
      done = 1'b1;
   end

endmodule
